// File: rtl/div_unit_if.sv
// Handshake and data bundle for div_unit.
// The sign wire exists only when DIV_SIGNED_EN is defined.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef DIV_SIGNED_EN
  logic             sign;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             div_zero;

  // Requester side: issues operands and observes results.
  modport master (
`ifdef DIV_SIGNED_EN
    output sign,
`endif
    output start, a, b,
    input  busy, done, quot, rem, div_zero
  );

  // Divider side.
  modport slave (
`ifdef DIV_SIGNED_EN
    input  sign,
`endif
    input  start, a, b,
    output busy, done, quot, rem, div_zero
  );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first.
// Define DIV_SIGNED_EN to add the sign input and signed (truncating) division.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] dvd;      // shifts dividend bits out, quotient bits in
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   prem;     // extra bit keeps the subtract borrow
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quot_q, rem_q;
  logic             dz_q;
  logic             neg_q;    // quotient must be negated at the end
  logic             negr_q;   // remainder must be negated at the end

  logic             zero_b, last_step;
  logic             sgn_a, sgn_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH+1:0] shifted, diff;
  logic             borrow;
  logic [WIDTH:0]   prem_step;
  logic [WIDTH-1:0] dvd_step, q_fin, r_fin;

  assign zero_b    = (bus.b == '0);
  assign last_step = (state == RUN) && (cnt == CW'(WIDTH - 1));

`ifdef DIV_SIGNED_EN
  assign sgn_a = bus.sign & bus.a[WIDTH-1];
  assign sgn_b = bus.sign & bus.b[WIDTH-1];
`else
  assign sgn_a = 1'b0;
  assign sgn_b = 1'b0;
`endif
  assign mag_a = sgn_a ? -bus.a : bus.a;
  assign mag_b = sgn_b ? -bus.b : bus.b;

  // One restoring step plus the sign-corrected final results.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path (here
    // unconditionally) so no latch can be inferred.
    shifted   = {prem, dvd[WIDTH-1]};
    diff      = shifted - {2'b00, dvs};
    borrow    = diff[WIDTH+1];
    prem_step = borrow ? shifted[WIDTH:0] : diff[WIDTH:0];
    dvd_step  = {dvd[WIDTH-2:0], ~borrow};
    q_fin     = neg_q  ? -dvd_step : dvd_step;
    r_fin     = negr_q ? -prem_step[WIDTH-1:0] : prem_step[WIDTH-1:0];
  end

  // State register; reset wins over everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = zero_b ? DONE : RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd    <= '0;
      dvs    <= '0;
      prem   <= '0;
      cnt    <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dz_q   <= 1'b0;
      neg_q  <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.start) begin
          if (zero_b) begin
            quot_q <= '1;
            rem_q  <= bus.a;
            dz_q   <= 1'b1;
          end else begin
            dvd    <= mag_a;
            dvs    <= mag_b;
            prem   <= '0;
            cnt    <= '0;
            neg_q  <= sgn_a ^ sgn_b;
            negr_q <= sgn_a;
          end
        end
        RUN: begin
          dvd  <= dvd_step;
          prem <= prem_step;
          cnt  <= cnt + 1'b1;
          if (last_step) begin
            quot_q <= q_fin;
            rem_q  <= r_fin;
            dz_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state == RUN);
  assign bus.done     = (state == DONE);
  assign bus.quot     = quot_q;
  assign bus.rem      = rem_q;
  assign bus.div_zero = dz_q;
endmodule
